tl_ul_master_seq: RTL and testbench
===================================

Name: tl_ul_master_seq

Overview:
- Parametrised TileLink-UL master sequencer for cosim behavioural tiles; next generation of the single-channel tile master model.
- Converts a simple command stream into A-channel Get/PutFullData/PutPartialData with up to NUM_SRC outstanding transactions, tracked by source ID.
- Returns D-channel responses on a response stream, with protocol checking and a watchdog.
- Sits between the cosim command mailbox and the tile's tl_master_xing_out A/D ports.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 64, data width; power of two, >= 8
- NUM_SRC, 4, source IDs available; 1..16
- SRC_W, 2, source field width; must satisfy 2^SRC_W >= NUM_SRC
- TIMEOUT, 1024, watchdog limit in cycles; 0 disables the watchdog

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-low reset (reset==0 asserts)
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when valid&&ready
- cmd_write  in  1  1=put, 0=get
- cmd_addr  in  ADDR_W  byte address
- cmd_size  in  4  log2 bytes
- cmd_mask  in  DATA_W/8  byte lanes
- cmd_data  in  DATA_W  write data
- a_ready  in  1  A-channel ready
- a_valid  out  1  A-channel valid
- a_opcode  out  3  A opcode
- a_param  out  3  A param
- a_size  out  4  A size
- a_source  out  SRC_W  A source ID
- a_address  out  ADDR_W  A address
- a_mask  out  DATA_W/8  A mask
- a_data  out  DATA_W  A data
- a_corrupt  out  1  A corrupt
- d_valid  in  1  D-channel valid
- d_ready  out  1  D-channel ready
- d_opcode  in  3  D opcode
- d_size  in  4  D size
- d_source  in  SRC_W  D source ID
- d_denied  in  1  D denied
- d_corrupt  in  1  D corrupt
- d_data  in  DATA_W  D data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_source  out  SRC_W  response source ID
- rsp_data  out  DATA_W  response data
- rsp_err  out  1  denied|corrupt|opcode mismatch
- outstanding  out  SRC_W+1  busy source count
- proto_err  out  1  sticky protocol error
- cmd_err  out  1  sticky illegal-command flag
- timeout  out  1  sticky watchdog flag
- clear_err  in  1  clears sticky flags

Behaviour:
- Reset: all outputs 0; busy[] cleared; watchdog counter 0. Reset mid-transaction discards all in-flight state; responses arriving later for those sources are flagged as proto_err.
- Source allocation: free = ~busy (registered value). The lowest-numbered free index below NUM_SRC is allocated. A source freed in cycle N is allocatable from cycle N+1.
- cmd_ready = any_free && (!a_valid || a_ready). This is combinational and does not depend on cmd_valid.
- On command accept:
  - A-register loads next cycle (1-cycle latency); busy[src] set; exp_data[src] = !cmd_write.
  - Opcode: read gives Get (4); write with all mask bits set gives PutFullData (0); other writes give PutPartialData (1).
  - a_param=0, a_corrupt=0; mask, size and address pass through unchanged.
- a_valid is held with stable bits until a_ready. It deasserts after the handshake unless a new command is accepted in the same cycle (back-to-back issue at full rate).
- Illegal command: cmd_size > log2(DATA_W/8) (multi-beat is unsupported).
  - Command is accepted and dropped; no A beat; no source allocated.
  - cmd_err set.
- d_ready = !rsp_valid || rsp_ready (1-entry output register).
- On D fire:
  - busy[d_source] cleared.
  - rsp_valid set next cycle with source and data.
  - rsp_err = d_denied | d_corrupt | mismatch, where mismatch means expected AccessAckData (1) for get, AccessAck (0) for put.
  - If busy[d_source]==0, or d_source >= NUM_SRC: proto_err set and the response is still forwarded.
- Same-cycle accept and D fire on different sources: both take effect; outstanding is unchanged net.
- Watchdog:
  - Counter increments each cycle while outstanding != 0 and no D fire occurs.
  - Clears on D fire or when outstanding==0.
  - At count==TIMEOUT, timeout is set and the counter saturates.
- clear_err clears all sticky flags. If an error event occurs in the same cycle, set wins.

Test Plan:
- Single get to 0x8000_0000 size 3 mask 0xFF, D AccessAckData data 0x1122334455667788 src 0 -> A opcode 4 src 0 one cycle after accept; rsp_data 0x1122334455667788, rsp_err 0.
- Four writes back-to-back with mask 0xFF then 0x0F, a_ready=1 -> sources 0,1,2,3; opcodes 0,0,0,1; fifth command cmd_ready=0 until first D; outstanding 4.
- D returned out of order (3,1,0,2) with rsp_ready toggling 50% -> responses in D order; no drops; outstanding reaches 0; d_ready low whenever rsp_valid && !rsp_ready.
- D with d_source=2 while idle; then get answered with AccessAck (0) -> proto_err=1; second rsp_err=1; clear_err -> proto_err=0.
- cmd_size=4 with DATA_W=64 -> no A beat; cmd_err=1; outstanding 0.
- TIMEOUT=16, one get with D withheld -> timeout=1 at cycle 16 after issue; reset=0 mid-wait -> all outputs 0; late D -> proto_err=1.

Source files
------------

// File: rtl/tl_ul_master_seq.sv
// TileLink-UL master sequencer: turns a command stream into A-channel
// Get/PutFullData/PutPartialData beats with per-source tracking, and
// returns D-channel responses through a one-entry response register.
// Protocol checking, illegal-command detection and a watchdog are included.
module tl_ul_master_seq #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned SRC_W   = 2,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                clock,
   input  logic                reset,
   // command stream
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [3:0]          cmd_size,
   input  logic [DATA_W/8-1:0] cmd_mask,
   input  logic [DATA_W-1:0]   cmd_data,
   // A channel
   input  logic                a_ready,
   output logic                a_valid,
   output logic [2:0]          a_opcode,
   output logic [2:0]          a_param,
   output logic [3:0]          a_size,
   output logic [SRC_W-1:0]    a_source,
   output logic [ADDR_W-1:0]   a_address,
   output logic [DATA_W/8-1:0] a_mask,
   output logic [DATA_W-1:0]   a_data,
   output logic                a_corrupt,
   // D channel
   input  logic                d_valid,
   output logic                d_ready,
   input  logic [2:0]          d_opcode,
   input  logic [3:0]          d_size,
   input  logic [SRC_W-1:0]    d_source,
   input  logic                d_denied,
   input  logic                d_corrupt,
   input  logic [DATA_W-1:0]   d_data,
   // response stream
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [SRC_W-1:0]    rsp_source,
   output logic [DATA_W-1:0]   rsp_data,
   output logic                rsp_err,
   // status
   output logic [SRC_W:0]      outstanding,
   output logic                proto_err,
   output logic                cmd_err,
   output logic                timeout,
   input  logic                clear_err
);

   localparam int unsigned MASK_W   = DATA_W / 8;
   localparam int unsigned SRC_N    = 1 << SRC_W;
   localparam int unsigned LG_BYTES = $clog2(MASK_W);
   localparam int unsigned CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {
      OP_PUT_FULL    = 3'd0,
      OP_PUT_PARTIAL = 3'd1,
      OP_GET         = 3'd4
   } a_op_e;

   typedef enum logic [2:0] {
      D_ACK      = 3'd0,
      D_ACK_DATA = 3'd1
   } d_op_e;

   // source tracking (sized to the full source field; entries >= NUM_SRC stay 0)
   logic [SRC_N-1:0]  busy_q, busy_d;
   logic [SRC_N-1:0]  exp_data_q, exp_data_d;
   logic              run_q;

   // A-channel register
   logic              a_valid_q, a_valid_d;
   a_op_e             a_opcode_q, a_opcode_d;
   logic [3:0]        a_size_q, a_size_d;
   logic [SRC_W-1:0]  a_source_q, a_source_d;
   logic [ADDR_W-1:0] a_address_q, a_address_d;
   logic [MASK_W-1:0] a_mask_q, a_mask_d;
   logic [DATA_W-1:0] a_data_q, a_data_d;

   // response register
   logic              rsp_valid_q, rsp_valid_d;
   logic [SRC_W-1:0]  rsp_source_q, rsp_source_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_err_q, rsp_err_d;

   // status
   logic [SRC_W:0]    outstanding_q, outstanding_d;
   logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;
   logic              proto_err_q, proto_err_d;
   logic              cmd_err_q, cmd_err_d;
   logic              timeout_q, timeout_d;

   logic              any_free;
   logic [SRC_W-1:0]  alloc_idx;
   logic              cmd_fire, cmd_legal, issue;
   logic              d_fire, d_src_known, mismatch;
   logic              unused_inputs;

   assign unused_inputs = ^d_size;

   // lowest-numbered free source below NUM_SRC
   always_comb begin
      any_free  = 1'b0;
      alloc_idx = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (!busy_q[i] && !any_free) begin
            any_free  = 1'b1;
            alloc_idx = SRC_W'(i);
         end
      end
   end

   // run_q keeps the ready outputs low while in reset and for the first cycle after
   assign cmd_ready = run_q && any_free && (!a_valid_q || a_ready);
   assign d_ready   = run_q && (!rsp_valid_q || rsp_ready);

   assign cmd_fire    = cmd_valid && cmd_ready;
   assign cmd_legal   = (cmd_size <= 4'(LG_BYTES));
   assign issue       = cmd_fire && cmd_legal;
   assign d_fire      = d_valid && d_ready;
   assign d_src_known = (32'(d_source) < NUM_SRC) && busy_q[d_source];
   assign mismatch    = exp_data_q[d_source] ? (d_opcode != D_ACK_DATA)
                                             : (d_opcode != D_ACK);

   // next-state for source tracking, A/response registers, watchdog and flags
   always_comb begin
      busy_d       = busy_q;
      exp_data_d   = exp_data_q;
      a_valid_d    = a_valid_q;
      a_opcode_d   = a_opcode_q;
      a_size_d     = a_size_q;
      a_source_d   = a_source_q;
      a_address_d  = a_address_q;
      a_mask_d     = a_mask_q;
      a_data_d     = a_data_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_source_d = rsp_source_q;
      rsp_data_d   = rsp_data_q;
      rsp_err_d    = rsp_err_q;
      wd_cnt_d     = wd_cnt_q;

      // free on D first, then allocate, so a same-cycle accept always sticks
      if (d_fire) begin
         busy_d[d_source] = 1'b0;
      end
      if (issue) begin
         busy_d[alloc_idx]     = 1'b1;
         exp_data_d[alloc_idx] = !cmd_write;
      end
      for (int unsigned i = NUM_SRC; i < SRC_N; i++) begin
         busy_d[i]     = 1'b0;
         exp_data_d[i] = 1'b0;
      end

      outstanding_d = '0;
      for (int unsigned i = 0; i < SRC_N; i++) begin
         outstanding_d = outstanding_d + (SRC_W+1)'(busy_d[i]);
      end

      if (issue) begin
         a_valid_d   = 1'b1;
         a_size_d    = cmd_size;
         a_source_d  = alloc_idx;
         a_address_d = cmd_addr;
         a_mask_d    = cmd_mask;
         a_data_d    = cmd_data;
         if (!cmd_write) begin
            a_opcode_d = OP_GET;
         end else if (&cmd_mask) begin
            a_opcode_d = OP_PUT_FULL;
         end else begin
            a_opcode_d = OP_PUT_PARTIAL;
         end
      end else if (a_ready) begin
         a_valid_d = 1'b0;
      end

      if (d_fire) begin
         rsp_valid_d  = 1'b1;
         rsp_source_d = d_source;
         rsp_data_d   = d_data;
         rsp_err_d    = d_denied || d_corrupt || mismatch;
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end

      if (TIMEOUT == 0 || d_fire || outstanding_q == '0) begin
         wd_cnt_d = '0;
      end else if (wd_cnt_q != CNT_W'(TIMEOUT)) begin
         wd_cnt_d = wd_cnt_q + CNT_W'(1);
      end

      // sticky flags: a set event in the same cycle beats clear_err
      if (d_fire && !d_src_known) begin
         proto_err_d = 1'b1;
      end else if (clear_err) begin
         proto_err_d = 1'b0;
      end else begin
         proto_err_d = proto_err_q;
      end

      if (cmd_fire && !cmd_legal) begin
         cmd_err_d = 1'b1;
      end else if (clear_err) begin
         cmd_err_d = 1'b0;
      end else begin
         cmd_err_d = cmd_err_q;
      end

      if (TIMEOUT != 0 && wd_cnt_d == CNT_W'(TIMEOUT)) begin
         timeout_d = 1'b1;
      end else if (clear_err) begin
         timeout_d = 1'b0;
      end else begin
         timeout_d = timeout_q;
      end
   end

   // state registers; reset discards all in-flight tracking
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         run_q         <= 1'b0;
         busy_q        <= '0;
         exp_data_q    <= '0;
         a_valid_q     <= 1'b0;
         a_opcode_q    <= OP_PUT_FULL;
         a_size_q      <= '0;
         a_source_q    <= '0;
         a_address_q   <= '0;
         a_mask_q      <= '0;
         a_data_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_source_q  <= '0;
         rsp_data_q    <= '0;
         rsp_err_q     <= 1'b0;
         outstanding_q <= '0;
         wd_cnt_q      <= '0;
         proto_err_q   <= 1'b0;
         cmd_err_q     <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         run_q         <= 1'b1;
         busy_q        <= busy_d;
         exp_data_q    <= exp_data_d;
         a_valid_q     <= a_valid_d;
         a_opcode_q    <= a_opcode_d;
         a_size_q      <= a_size_d;
         a_source_q    <= a_source_d;
         a_address_q   <= a_address_d;
         a_mask_q      <= a_mask_d;
         a_data_q      <= a_data_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_source_q  <= rsp_source_d;
         rsp_data_q    <= rsp_data_d;
         rsp_err_q     <= rsp_err_d;
         outstanding_q <= outstanding_d;
         wd_cnt_q      <= wd_cnt_d;
         proto_err_q   <= proto_err_d;
         cmd_err_q     <= cmd_err_d;
         timeout_q     <= timeout_d;
      end
   end

   assign a_valid     = a_valid_q;
   assign a_opcode    = a_opcode_q;
   assign a_param     = '0;
   assign a_size      = a_size_q;
   assign a_source    = a_source_q;
   assign a_address   = a_address_q;
   assign a_mask      = a_mask_q;
   assign a_data      = a_data_q;
   assign a_corrupt   = 1'b0;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_source  = rsp_source_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_err     = rsp_err_q;
   assign outstanding = outstanding_q;
   assign proto_err   = proto_err_q;
   assign cmd_err     = cmd_err_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_tl_ul_master_seq.sv
// Directed bench for tl_ul_master_seq (64-bit data, 4 sources, 16-cycle watchdog).
module tb_tl_ul_master_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr;
   logic [3:0]  cmd_size;
   logic [7:0]  cmd_mask;
   logic [63:0] cmd_data;
   logic        a_ready, a_valid, a_corrupt;
   logic [2:0]  a_opcode, a_param;
   logic [3:0]  a_size;
   logic [1:0]  a_source;
   logic [31:0] a_address;
   logic [7:0]  a_mask;
   logic [63:0] a_data;
   logic        d_valid, d_ready, d_denied, d_corrupt;
   logic [2:0]  d_opcode;
   logic [3:0]  d_size;
   logic [1:0]  d_source;
   logic [63:0] d_data;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [1:0]  rsp_source;
   logic [63:0] rsp_data;
   logic [2:0]  outstanding;
   logic        proto_err, cmd_err, timeout, clear_err;

   tl_ul_master_seq #(
      .ADDR_W(32), .DATA_W(64), .NUM_SRC(4), .SRC_W(2), .TIMEOUT(16)
   ) dut (
      .clock(clk), .reset(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_mask(cmd_mask), .cmd_data(cmd_data),
      .a_ready(a_ready), .a_valid(a_valid), .a_opcode(a_opcode), .a_param(a_param),
      .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
      .a_data(a_data), .a_corrupt(a_corrupt),
      .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
      .d_source(d_source), .d_denied(d_denied), .d_corrupt(d_corrupt), .d_data(d_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_source(rsp_source),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
      .outstanding(outstanding), .proto_err(proto_err), .cmd_err(cmd_err),
      .timeout(timeout), .clear_err(clear_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [7:0]  mask;
      logic [63:0] data;
      logic [2:0]  exp_op;
      logic [1:0]  exp_src;
   } cmd_vec_t;

   typedef struct {
      logic [1:0]  src;
      logic [2:0]  op;
      logic [63:0] data;
      logic        exp_err;
   } d_vec_t;

   cmd_vec_t cv [4];
   d_vec_t   dv [5];
   int       n_vec = 0;
   int       n_err = 0;
   int       mon_i = 0;
   logic     mon_en = 1'b0;
   logic     tog_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [3:0] size,
                           input logic [7:0] mask, input logic [63:0] data);
      int k;
      cmd_write = wr; cmd_addr = addr; cmd_size = size; cmd_mask = mask; cmd_data = data;
      cmd_valid = 1'b1;
      #1;
      k = 0;
      while (!cmd_ready && k < 50) begin tick(); k++; end
      if (k == 50) begin
         n_vec++; n_err++;
         $display("FAIL cmd_wait: cmd_ready stayed 0 for %0d cycles", k);
      end
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic send_d(input logic [1:0] src, input logic [2:0] op, input logic den,
                         input logic cor, input logic [63:0] data);
      int k;
      d_source = src; d_opcode = op; d_denied = den; d_corrupt = cor; d_data = data;
      d_valid = 1'b1;
      #1;
      k = 0;
      while (!d_ready && k < 50) begin tick(); k++; end
      if (k == 50) begin
         n_vec++; n_err++;
         $display("FAIL d_wait: d_ready stayed 0 for %0d cycles", k);
      end
      tick();
      d_valid = 1'b0; d_denied = 1'b0; d_corrupt = 1'b0;
   endtask

   task automatic pulse_clear();
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      cv[0] = '{1'b1, 32'h0000_1000, 8'hFF, 64'h0000_0000_0000_00A0, 3'd0, 2'd0};
      cv[1] = '{1'b1, 32'h0000_1008, 8'hFF, 64'h0000_0000_0000_00A1, 3'd0, 2'd1};
      cv[2] = '{1'b1, 32'h0000_1010, 8'hFF, 64'h0000_0000_0000_00A2, 3'd0, 2'd2};
      cv[3] = '{1'b1, 32'h0000_1018, 8'h0F, 64'h0000_0000_0000_00A3, 3'd1, 2'd3};
      dv[0] = '{2'd3, 3'd0, 64'h3333_0000_0000_0003, 1'b0};
      dv[1] = '{2'd1, 3'd0, 64'h1111_0000_0000_0001, 1'b0};
      dv[2] = '{2'd0, 3'd0, 64'h0000_0000_0000_0000, 1'b0};
      dv[3] = '{2'd2, 3'd0, 64'h2222_0000_0000_0002, 1'b0};
      dv[4] = '{2'd3, 3'd1, 64'hCAFE_F00D_1234_5678, 1'b0};

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0;
      cmd_mask = '0; cmd_data = '0; a_ready = 1'b0; d_valid = 1'b0; d_opcode = '0;
      d_size = 4'd3; d_source = '0; d_denied = 1'b0; d_corrupt = 1'b0; d_data = '0;
      rsp_ready = 1'b1; clear_err = 1'b0;

      // reset state
      tick(); tick();
      chk("rst_a_valid", a_valid, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_d_ready", d_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_flags", {proto_err, cmd_err, timeout}, 0);
      rst_n = 1'b1;
      tick();

      // single get, A held while a_ready low
      send_cmd(1'b0, 32'h8000_0000, 4'd3, 8'hFF, 64'h0);
      chk("get_a_valid", a_valid, 1);
      chk("get_a_opcode", a_opcode, 4);
      chk("get_a_source", a_source, 0);
      chk("get_a_address", a_address, 64'h8000_0000);
      chk("get_a_size_mask", {a_size, a_mask}, {4'd3, 8'hFF});
      chk("get_a_param_corrupt", {a_param, a_corrupt}, 0);
      chk("get_outstanding", outstanding, 1);
      tick();
      chk("get_a_hold", {a_valid, a_opcode, a_source}, {1'b1, 3'd4, 2'd0});
      chk("get_cmd_ready_stall", cmd_ready, 0);
      a_ready = 1'b1;
      tick();
      chk("get_a_drop", a_valid, 0);
      send_d(2'd0, 3'd1, 1'b0, 1'b0, 64'h1122_3344_5566_7788);
      chk("get_rsp_valid", rsp_valid, 1);
      chk("get_rsp_data", rsp_data, 64'h1122_3344_5566_7788);
      chk("get_rsp_src_err", {rsp_source, rsp_err}, 0);
      chk("get_outstanding0", outstanding, 0);
      tick();

      // four back-to-back writes
      for (int i = 0; i < 4; i++) begin
         send_cmd(cv[i].wr, cv[i].addr, 4'd3, cv[i].mask, cv[i].data);
         chk($sformatf("wr%0d_a_opcode", i), a_opcode, cv[i].exp_op);
         chk($sformatf("wr%0d_a_source", i), a_source, cv[i].exp_src);
         chk($sformatf("wr%0d_a_addr_mask", i), {a_address, a_mask}, {cv[i].addr, cv[i].mask});
         chk($sformatf("wr%0d_a_data", i), a_data, cv[i].data);
      end
      chk("wr_outstanding4", outstanding, 4);

      // fifth command stalls until the first D frees a source
      cmd_write = 1'b0; cmd_addr = 32'h0000_2000; cmd_size = 4'd3; cmd_mask = 8'hFF;
      cmd_valid = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("fifth_cmd_ready_low", cmd_ready, 0);
         tick();
      end

      // out-of-order D with rsp_ready toggling every cycle
      mon_en = 1'b1;
      tog_en = 1'b1;
      fork
         begin
            while (tog_en) begin
               @(negedge clk);
               rsp_ready = ~rsp_ready;
            end
         end
         begin
            forever begin
               @(negedge clk);
               #2;
               if (mon_en) begin
                  chk("d_ready_vs_rsp", d_ready, !(rsp_valid && !rsp_ready));
                  if (rsp_valid && rsp_ready) begin
                     if (mon_i < 5) begin
                        chk($sformatf("ooo%0d_rsp", mon_i), {rsp_err, rsp_source, rsp_data},
                            {dv[mon_i].exp_err, dv[mon_i].src, dv[mon_i].data});
                     end else begin
                        chk("ooo_extra_rsp", mon_i, 4);
                     end
                     mon_i++;
                  end
               end
            end
         end
      join_none

      send_d(dv[0].src, dv[0].op, 1'b0, 1'b0, dv[0].data);
      chk("fifth_cmd_ready_high", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      chk("fifth_a_src_op", {a_source, a_opcode}, {2'd3, 3'd4});
      chk("fifth_outstanding", outstanding, 4);
      for (int i = 1; i < 5; i++) begin
         send_d(dv[i].src, dv[i].op, 1'b0, 1'b0, dv[i].data);
      end
      for (int k = 0; k < 20 && mon_i < 5; k++) tick();
      tog_en = 1'b0;
      tick(); tick();
      mon_en = 1'b0;
      rsp_ready = 1'b1;
      chk("ooo_rsp_count", mon_i, 5);
      chk("ooo_outstanding0", outstanding, 0);
      chk("ooo_proto_err", proto_err, 0);
      tick();

      // protocol errors and clear_err
      pulse_clear();
      chk("proto_cleared", proto_err, 0);
      clear_err = 1'b1;
      send_d(2'd2, 3'd0, 1'b0, 1'b0, 64'h5);
      clear_err = 1'b0;
      chk("idle_d_proto_set_wins", proto_err, 1);
      chk("idle_d_forwarded", {rsp_valid, rsp_source, rsp_data}, {1'b1, 2'd2, 64'h5});
      send_cmd(1'b0, 32'h0000_3000, 4'd3, 8'hFF, 64'h0);
      chk("proto_get_src", a_source, 0);
      send_d(2'd0, 3'd0, 1'b0, 1'b0, 64'h0);
      chk("get_ack_mismatch_err", rsp_err, 1);
      send_cmd(1'b1, 32'h0000_3008, 4'd3, 8'hFF, 64'h77);
      send_d(2'd0, 3'd0, 1'b0, 1'b0, 64'h0);
      chk("put_ack_ok", rsp_err, 0);
      send_cmd(1'b0, 32'h0000_3010, 4'd3, 8'hFF, 64'h0);
      send_d(2'd0, 3'd1, 1'b1, 1'b0, 64'h9);
      chk("denied_err", rsp_err, 1);
      send_cmd(1'b1, 32'h0000_3018, 4'd2, 8'h0F, 64'h8);
      chk("partial_size2_op", {a_opcode, a_size}, {3'd1, 4'd2});
      send_d(2'd0, 3'd0, 1'b0, 1'b1, 64'h0);
      chk("corrupt_err", rsp_err, 1);
      chk("proto_still_set", proto_err, 1);
      pulse_clear();
      chk("proto_after_clear", proto_err, 0);

      // illegal command size
      send_cmd(1'b1, 32'h0000_4000, 4'd4, 8'hFF, 64'h1);
      chk("illegal_no_a", a_valid, 0);
      chk("illegal_cmd_err", cmd_err, 1);
      chk("illegal_outstanding0", outstanding, 0);
      tick();
      chk("illegal_still_no_a", a_valid, 0);
      pulse_clear();
      chk("cmd_err_cleared", {cmd_err, timeout}, 0);

      // watchdog, then reset mid-wait and a late D
      send_cmd(1'b0, 32'h0000_5000, 4'd3, 8'hFF, 64'h0);
      repeat (15) tick();
      chk("wd_before_limit", timeout, 0);
      tick();
      chk("wd_at_limit", timeout, 1);
      chk("wd_outstanding", outstanding, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_a_rsp", {a_valid, a_opcode, a_source, rsp_valid}, 0);
      chk("midrst_ready", {cmd_ready, d_ready}, 0);
      chk("midrst_outstanding", outstanding, 0);
      chk("midrst_flags", {proto_err, cmd_err, timeout}, 0);
      tick();
      rst_n = 1'b1;
      tick();
      send_d(2'd0, 3'd1, 1'b0, 1'b0, 64'hDEAD);
      chk("late_d_proto_err", proto_err, 1);
      chk("late_d_forwarded", {rsp_valid, rsp_data}, {1'b1, 64'hDEAD});
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
